// File: rtl/lsu_store_queue.sv
// Store queue between execute and data memory: buffers aligned stores, drains them
// oldest-first, and forwards store bytes to younger loads that hit the same word.
module lsu_store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [ADDR_W-1:0]        enq_addr,
    input  logic [31:0]              enq_data,
    input  logic [1:0]               enq_size,
    input  logic                     branch_squash,
    output logic                     enq_ready,
    output logic                     misalign_err,
    output logic                     mem_wr_valid,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [31:0]              mem_wr_data,
    output logic [3:0]               mem_wr_be,
    input  logic                     mem_wr_ready,
    input  logic                     ld_check,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [1:0]               ld_size,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-3:0] ent_addr [DEPTH];
    logic [3:0]        ent_be   [DEPTH];
    logic [31:0]       ent_data [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic             misaligned, enq_fire, deq_fire;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_mask = 4'b0001 << a;
            2'b01:   byte_mask = 4'b0011 << {a[1], 1'b0};
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
    // valid never waits on ready, and the presented payload holds until the transfer.
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign enq_ready  = !full;
    assign misaligned = (enq_size == 2'b01) ? enq_addr[0] :
                        (enq_size[1]        ? (enq_addr[1:0] != 2'b00) : 1'b0);
    assign enq_fire   = enq_valid && enq_ready && !branch_squash && !misaligned;

    assign mem_wr_valid = !empty;
    assign deq_fire     = mem_wr_valid && mem_wr_ready;
    assign mem_wr_addr  = empty ? '0 : {ent_addr[head], 2'b00};
    assign mem_wr_data  = empty ? '0 : ent_data[head];
    assign mem_wr_be    = empty ? '0 : ent_be[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= enq_valid && enq_ready && !branch_squash && misaligned;
            if (enq_fire) tail <= tail + 1'b1;
            if (deq_fire) head <= head + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload is deliberately left unreset; the mem_wr_* gating above hides stale entries.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ent_addr[tail] <= enq_addr[ADDR_W-1:2];
            ent_be[tail]   <= byte_mask(enq_size, enq_addr[1:0]);
            ent_data[tail] <= enq_data << {enq_addr[1:0], 3'b000};
        end
    end

    logic [3:0]       ld_mask, m_be;
    logic [31:0]      m_data;
    logic [PTR_W-1:0] idx;
    logic             any_lane, covered;

    // Walk oldest to newest so that, per byte lane, the youngest writer wins.
    always_comb begin
        ld_mask = byte_mask(ld_size, ld_addr[1:0]);
        m_be    = '0;
        m_data  = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[idx] == ld_addr[ADDR_W-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_be[idx][b]) begin
                        m_be[b]         = 1'b1;
                        m_data[b*8 +: 8] = ent_data[idx][b*8 +: 8];
                    end
                end
            end
        end
        any_lane    = |(m_be & ld_mask);
        covered     = ((m_be & ld_mask) == ld_mask);
        ld_hit      = ld_check && any_lane && covered;
        ld_conflict = ld_check && any_lane && !covered;
        ld_data     = ld_hit ? m_data : 32'h0;
    end
endmodule

// File: tb/tb_lsu_store_queue.sv
// Directed bench for lsu_store_queue: enqueue/drain, full handling, forwarding,
// partial-overlap conflicts, misalignment, squash and asynchronous reset.
module tb_lsu_store_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, branch_squash, enq_ready, misalign_err;
    logic [31:0] enq_addr, enq_data;
    logic [1:0]  enq_size;
    logic        mem_wr_valid, mem_wr_ready;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic        ld_check, ld_hit, ld_conflict;
    logic [31:0] ld_addr, ld_data;
    logic [1:0]  ld_size;
    logic [2:0]  count;
    logic        full, empty;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_a_q[$];

    lsu_store_queue #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_size(enq_size),
        .branch_squash(branch_squash), .enq_ready(enq_ready), .misalign_err(misalign_err),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
        .ld_check(ld_check), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
        .count(count), .full(full), .empty(empty)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_size = sz;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz);
        ld_check = 1'b1; ld_addr = a; ld_size = sz;
        #1;
    endtask

    task automatic test_reset();
        n_run++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_run++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
        n_run++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready got %b exp 1", enq_ready); end
        n_run++; if (mem_wr_valid !== 1'b0 || mem_wr_addr !== 32'h0 || mem_wr_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem got v=%b a=%h be=%b exp 0", mem_wr_valid, mem_wr_addr, mem_wr_be); end
        n_run++; if (misalign_err !== 1'b0 || ld_hit !== 1'b0 || ld_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_misc got err=%b hit=%b conf=%b exp 0", misalign_err, ld_hit, ld_conflict); end
    endtask

    task automatic test_basic();
        mem_wr_ready = 1'b0;
        enq(32'h0000_1003, 32'h0000_00AB, 2'b00);
        n_run++; if (mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid got %b exp 1", mem_wr_valid); end
        n_run++; if (mem_wr_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr got %h exp 00001000", mem_wr_addr); end
        n_run++; if (mem_wr_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b exp 1000", mem_wr_be); end
        n_run++; if (mem_wr_data !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_data got %h exp ab000000", mem_wr_data); end
        n_run++; if (count !== 3'd1) begin n_fail++; $display("FAIL sb_count got %0d exp 1", count); end
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        n_run++; if (empty !== 1'b1 || mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL sb_drain got empty=%b v=%b exp 1/0", empty, mem_wr_valid); end
    endtask

    task automatic test_full();
        logic [31:0] e_d, e_a;
        mem_wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enq(32'h0000_0100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 2'b10);
            exp_a_q.push_back(32'h0000_0100 + 32'(4 * k));
            exp_q.push_back(32'hC0DE_0000 + 32'(k));
        end
        n_run++; if (enq_ready !== 1'b0 || full !== 1'b1) begin n_fail++; $display("FAIL full_ready got rdy=%b full=%b exp 0/1", enq_ready, full); end
        enq(32'h0000_0110, 32'hDEAD_BEEF, 2'b10);
        n_run++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth got count=%0d exp 4", count); end
        mem_wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e_d = exp_q.pop_front();
            e_a = exp_a_q.pop_front();
            n_run++; if (mem_wr_data !== e_d || mem_wr_addr !== e_a || mem_wr_be !== 4'hF) begin n_fail++; $display("FAIL drain_order beat %0d got %h@%h be=%b exp %h@%h be=1111", k, mem_wr_data, mem_wr_addr, mem_wr_be, e_d, e_a); end
            tick();
        end
        mem_wr_ready = 1'b0;
        n_run++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL full_empty got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_forward();
        mem_wr_ready = 1'b0;
        enq_valid = 1'b1; enq_addr = 32'h2000; enq_data = 32'h1122_3344; enq_size = 2'b10;
        load(32'h2000, 2'b10);
        n_run++; if (ld_hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_invisible got hit=%b exp 0", ld_hit); end
        tick();
        enq_valid = 1'b0;
        n_run++; if (ld_hit !== 1'b1 || ld_data !== 32'h1122_3344) begin n_fail++; $display("FAIL sw_fwd got hit=%b data=%h exp 1/11223344", ld_hit, ld_data); end
        enq(32'h2000, 32'h0000_0055, 2'b00);
        load(32'h2000, 2'b10);
        n_run++; if (ld_hit !== 1'b1 || ld_conflict !== 1'b0 || ld_data !== 32'h1122_3355) begin n_fail++; $display("FAIL lw_merge got hit=%b conf=%b data=%h exp 1/0/11223355", ld_hit, ld_conflict, ld_data); end
        load(32'h2002, 2'b01);
        n_run++; if (ld_hit !== 1'b1 || ld_data !== 32'h1122_3355) begin n_fail++; $display("FAIL lh_fwd got hit=%b data=%h exp 1/11223355", ld_hit, ld_data); end
        load(32'h2000, 2'b10);
        mem_wr_ready = 1'b1;
        #1;
        n_run++; if (ld_hit !== 1'b1 || ld_data !== 32'h1122_3355) begin n_fail++; $display("FAIL head_in_handshake got hit=%b data=%h exp 1/11223355", ld_hit, ld_data); end
        tick();
        mem_wr_ready = 1'b0;
        n_run++; if (ld_conflict !== 1'b1 || ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL after_head_drain got conf=%b hit=%b data=%h exp 1/0/0", ld_conflict, ld_hit, ld_data); end
        ld_check = 1'b0;
        #1;
        n_run++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL no_check got hit=%b conf=%b data=%h exp 0/0/0", ld_hit, ld_conflict, ld_data); end
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_conflict();
        mem_wr_ready = 1'b0;
        enq(32'h3001, 32'h0000_0077, 2'b00);
        load(32'h3000, 2'b10);
        n_run++; if (ld_conflict !== 1'b1 || ld_hit !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL partial_lw got conf=%b hit=%b data=%h exp 1/0/0", ld_conflict, ld_hit, ld_data); end
        load(32'h3002, 2'b00);
        n_run++; if (ld_conflict !== 1'b0 || ld_hit !== 1'b0) begin n_fail++; $display("FAIL disjoint_lb got conf=%b hit=%b exp 0/0", ld_conflict, ld_hit); end
        load(32'h3001, 2'b00);
        n_run++; if (ld_hit !== 1'b1 || ld_data !== 32'h0000_7700) begin n_fail++; $display("FAIL exact_lb got hit=%b data=%h exp 1/00007700", ld_hit, ld_data); end
        load(32'h7001, 2'b00);
        n_run++; if (ld_hit !== 1'b0 || ld_conflict !== 1'b0) begin n_fail++; $display("FAIL other_word got hit=%b conf=%b exp 0/0", ld_hit, ld_conflict); end
        ld_check = 1'b0;
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_misalign();
        enq(32'h4001, 32'h0000_BEEF, 2'b01);
        n_run++; if (misalign_err !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL sh_misalign got err=%b count=%0d exp 1/0", misalign_err, count); end
        tick();
        n_run++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b exp 0", misalign_err); end
        enq(32'h4002, 32'h1234_5678, 2'b11);
        n_run++; if (misalign_err !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL sw11_misalign got err=%b count=%0d exp 1/0", misalign_err, count); end
        branch_squash = 1'b1;
        enq(32'h4000, 32'h0000_0011, 2'b00);
        n_run++; if (count !== 3'd0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL squash_store got count=%0d err=%b exp 0/0", count, misalign_err); end
        enq(32'h4001, 32'h0000_0022, 2'b01);
        n_run++; if (misalign_err !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL squash_misalign got err=%b count=%0d exp 0/0", misalign_err, count); end
        branch_squash = 1'b0;
        enq(32'h4002, 32'h0000_ABCD, 2'b01);
        n_run++; if (count !== 3'd1 || mem_wr_be !== 4'b1100 || mem_wr_data !== 32'hABCD_0000) begin n_fail++; $display("FAIL sh_aligned got count=%0d be=%b data=%h exp 1/1100/abcd0000", count, mem_wr_be, mem_wr_data); end
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) enq(32'h6000 + 32'(4 * k), 32'hA0 + 32'(k), 2'b10);
        enq_valid = 1'b1; enq_addr = 32'h6010; enq_data = 32'hEE; enq_size = 2'b10;
        mem_wr_ready = 1'b1;
        tick();
        enq_valid = 1'b0; mem_wr_ready = 1'b0;
        n_run++; if (count !== 3'd3 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_simul got count=%0d rdy=%b exp 3/1", count, enq_ready); end
        n_run++; if (mem_wr_data !== 32'hA1 || mem_wr_addr !== 32'h6004) begin n_fail++; $display("FAIL full_simul_head got %h@%h exp 000000a1@00006004", mem_wr_data, mem_wr_addr); end
        mem_wr_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_run++; if (count !== 3'd0 || empty !== 1'b1 || enq_ready !== 1'b1 || mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset got count=%0d empty=%b rdy=%b v=%b exp 0/1/1/0", count, empty, enq_ready, mem_wr_valid); end
        n_run++; if (mem_wr_addr !== 32'h0 || mem_wr_data !== 32'h0 || mem_wr_be !== 4'h0) begin n_fail++; $display("FAIL async_reset_bus got a=%h d=%h be=%b exp 0", mem_wr_addr, mem_wr_data, mem_wr_be); end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_run++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet cycle %0d got v=%b exp 0", k, mem_wr_valid); end
        end
        mem_wr_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_size = '0; branch_squash = 1'b0;
        mem_wr_ready = 1'b0; ld_check = 1'b0; ld_addr = '0; ld_size = '0;
        #12;
        test_reset();
        rst = 1'b1;
        tick();
        test_basic();
        test_full();
        test_forward();
        test_conflict();
        test_misalign();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
